// File: rtl/mac_lookup_req_pkg.sv
// Shared types, constants and the reference 48->14 MAC fold used by the
// MAC lookup request engine.
package mac_lookup_req_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_REQ,
    ST_WAIT,
    ST_DEC
  } state_t;

  typedef logic [47:0] mac_t;

  localparam mac_t MAC_BCAST = 48'hFFFF_FFFF_FFFF;
  localparam int   HASH_W    = 14;
  localparam int   MC_BIT    = 40;

  // Zero-extend to 56 bits and XOR the four 14-bit slices together.
  function automatic logic [HASH_W-1:0] mac_fold14(input mac_t mac);
    logic [4*HASH_W-1:0] ext;
    ext = {8'h00, mac};
    return ext[13:0] ^ ext[27:14] ^ ext[41:28] ^ ext[55:42];
  endfunction

endpackage

// File: rtl/mac_lookup_req_hash.sv
// Combinational fold of a 48-bit MAC down to a pADDR_WIDTH table index.
module mac_hash
  import mac_lookup_req_pkg::*;
#(
  parameter int pADDR_WIDTH = 14
) (
  input  mac_t                   imac,
  output logic [pADDR_WIDTH-1:0] ohash
);

  generate
    if (pADDR_WIDTH == HASH_W) begin : g_pkg
      assign ohash = mac_fold14(imac);
    end else begin : g_gen
      localparam int NSL   = (48 + pADDR_WIDTH - 1) / pADDR_WIDTH;
      localparam int EXT_W = NSL * pADDR_WIDTH;
      logic [EXT_W-1:0] ext;
      always_comb begin
        ext   = EXT_W'(imac);
        ohash = '0;
        for (int i = 0; i < NSL; i++) begin
          ohash = ohash ^ ext[i*pADDR_WIDTH +: pADDR_WIDTH];
        end
      end
    end
  endgenerate

endmodule

// File: rtl/mac_lookup_req.sv
// Parses DA/SA from the frame header, issues a learn/lookup to the MAC table
// and produces a one-cycle forwarding decision with an egress port mask.
module mac_lookup_req
  import mac_lookup_req_pkg::*;
#(
  parameter int pNUM_PORTS  = 4,
  parameter int pADDR_WIDTH = 14,
  parameter int pLOOKUP_LAT = 3,
  localparam int PW = (pNUM_PORTS > 1) ? $clog2(pNUM_PORTS) : 1
) (
  input  logic                   iclk,
  input  logic                   irst_n,
  input  logic                   ivalid,
  input  logic                   isof,
  input  logic                   ieof,
  input  logic [7:0]             idata,
  input  logic [PW-1:0]          iport,
  input  logic                   itbl_ready,
  input  logic [PW-1:0]          itbl_pnum,
  output logic [pADDR_WIDTH-1:0] osa,
  output logic [pADDR_WIDTH-1:0] oda,
  output logic [PW-1:0]          opnum,
  output logic                   owr_en,
  output logic                   odec_valid,
  output logic [pNUM_PORTS-1:0]  odec_mask,
  output logic                   obusy,
  output logic [15:0]            ocnt_runt,
  output logic [15:0]            ocnt_ovr
);

  localparam int            LW       = (pLOOKUP_LAT > 1) ? $clog2(pLOOKUP_LAT) : 1;
  localparam logic [LW-1:0] LAT_LAST = LW'(pLOOKUP_LAT - 1);

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [pNUM_PORTS-1:0] calc_mask(input mac_t da,
                                                      input logic [PW-1:0] ingress,
                                                      input logic [PW-1:0] pnum);
    logic [pNUM_PORTS-1:0] one;
    one = pNUM_PORTS'(1);
    if (da == MAC_BCAST || da[MC_BIT]) return ~(one << ingress);
    else if (pnum == ingress)          return '0;
    else                               return one << pnum;
  endfunction

  state_t                  state_q, state_d;
  logic [3:0]              bcnt_q, bcnt_d;
  logic [LW-1:0]           lcnt_q, lcnt_d;
  mac_t                    da_q, da_d, sa_q, sa_d;
  logic [PW-1:0]           port_q, port_d;
  logic [pADDR_WIDTH-1:0]  oda_q, oda_d, osa_q, osa_d;
  logic [PW-1:0]           opnum_q, opnum_d;
  logic [pNUM_PORTS-1:0]   mask_q, mask_d;
  logic [15:0]             runt_q, runt_d, ovr_q, ovr_d;
  logic [pADDR_WIDTH-1:0]  da_hash, sa_hash;
  logic                    sof, eof, wr_en;

  assign sof = ivalid & isof;
  assign eof = ivalid & ieof;

  // Hash the next-state MACs so the indices are ready the cycle REQ is entered.
  mac_hash #(.pADDR_WIDTH(pADDR_WIDTH)) u_da_hash (.imac(da_d), .ohash(da_hash));
  mac_hash #(.pADDR_WIDTH(pADDR_WIDTH)) u_sa_hash (.imac(sa_d), .ohash(sa_hash));

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    lcnt_d  = lcnt_q;
    da_d    = da_q;
    sa_d    = sa_q;
    port_d  = port_q;
    oda_d   = oda_q;
    osa_d   = osa_q;
    opnum_d = opnum_q;
    mask_d  = mask_q;
    runt_d  = runt_q;
    ovr_d   = ovr_q;
    wr_en   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (sof && eof) begin
          runt_d = sat_inc(runt_q);
        end else if (sof) begin
          state_d = ST_HDR;
          bcnt_d  = 4'd1;
          port_d  = iport;
          da_d    = {da_q[39:0], idata};
        end
      end
      ST_HDR: begin
        if (sof && eof) begin
          runt_d  = sat_inc(runt_q);
          state_d = ST_IDLE;
        end else if (sof) begin
          bcnt_d = 4'd1;
          port_d = iport;
          da_d   = {da_q[39:0], idata};
        end else if (ivalid) begin
          if (bcnt_q < 4'd6) da_d = {da_q[39:0], idata};
          else               sa_d = {sa_q[39:0], idata};
          if (bcnt_q == 4'd11) begin
            state_d = ST_REQ;
            oda_d   = da_hash;
            osa_d   = sa_hash;
            opnum_d = port_q;
          end else if (eof) begin
            runt_d  = sat_inc(runt_q);
            state_d = ST_IDLE;
          end else begin
            bcnt_d = bcnt_q + 4'd1;
          end
        end
      end
      ST_REQ: begin
        if (itbl_ready) begin
          wr_en   = 1'b1;
          state_d = ST_WAIT;
          lcnt_d  = '0;
        end
      end
      ST_WAIT: begin
        // A closed window means the table may have lost the request: reissue.
        if (!itbl_ready) begin
          state_d = ST_REQ;
        end else if (lcnt_q == LAT_LAST) begin
          mask_d  = calc_mask(da_q, port_q, itbl_pnum);
          state_d = ST_DEC;
        end else begin
          lcnt_d = lcnt_q + LW'(1);
        end
      end
      ST_DEC: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (sof && (state_q == ST_REQ || state_q == ST_WAIT || state_q == ST_DEC)) begin
      ovr_d = sat_inc(ovr_q);
    end
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      state_q <= ST_IDLE;
      bcnt_q  <= '0;
      lcnt_q  <= '0;
      da_q    <= '0;
      sa_q    <= '0;
      port_q  <= '0;
      oda_q   <= '0;
      osa_q   <= '0;
      opnum_q <= '0;
      mask_q  <= '0;
      runt_q  <= '0;
      ovr_q   <= '0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      lcnt_q  <= lcnt_d;
      da_q    <= da_d;
      sa_q    <= sa_d;
      port_q  <= port_d;
      oda_q   <= oda_d;
      osa_q   <= osa_d;
      opnum_q <= opnum_d;
      mask_q  <= mask_d;
      runt_q  <= runt_d;
      ovr_q   <= ovr_d;
    end
  end

  assign osa        = osa_q;
  assign oda        = oda_q;
  assign opnum      = opnum_q;
  assign owr_en     = wr_en;
  assign odec_valid = (state_q == ST_DEC);
  assign odec_mask  = (state_q == ST_DEC) ? mask_q : '0;
  assign obusy      = (state_q != ST_IDLE);
  assign ocnt_runt  = runt_q;
  assign ocnt_ovr   = ovr_q;

endmodule

// File: tb/tb_mac_lookup_req.sv
// Self-checking bench for mac_lookup_req: directed vector table, multi-cycle
// corner sequences and randomized frames against a behavioural model.
module tb_mac_lookup_req;

  localparam int LAT = 3;

  logic        iclk = 1'b0;
  logic        irst_n;
  logic        ivalid, isof, ieof;
  logic [7:0]  idata;
  logic [1:0]  iport;
  logic        itbl_ready;
  logic [1:0]  itbl_pnum;
  logic [13:0] osa, oda;
  logic [1:0]  opnum;
  logic        owr_en, odec_valid, obusy;
  logic [3:0]  odec_mask;
  logic [15:0] ocnt_runt, ocnt_ovr;

  mac_lookup_req #(.pNUM_PORTS(4), .pADDR_WIDTH(14), .pLOOKUP_LAT(LAT)) dut (
    .iclk(iclk), .irst_n(irst_n), .ivalid(ivalid), .isof(isof), .ieof(ieof),
    .idata(idata), .iport(iport), .itbl_ready(itbl_ready), .itbl_pnum(itbl_pnum),
    .osa(osa), .oda(oda), .opnum(opnum), .owr_en(owr_en), .odec_valid(odec_valid),
    .odec_mask(odec_mask), .obusy(obusy), .ocnt_runt(ocnt_runt), .ocnt_ovr(ocnt_ovr)
  );

  always #5 iclk = ~iclk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int exp_runt = 0;
  int exp_ovr  = 0;

  int          wr_cyc[$];
  logic [13:0] wr_sa[$], wr_da[$];
  logic [1:0]  wr_pn[$];
  int          dec_cyc[$];
  logic [3:0]  dec_mask[$];

  always @(negedge iclk) begin
    cyc <= cyc + 1;
    if (owr_en) begin
      wr_cyc.push_back(cyc);
      wr_sa.push_back(osa);
      wr_da.push_back(oda);
      wr_pn.push_back(opnum);
    end
    if (odec_valid) begin
      dec_cyc.push_back(cyc);
      dec_mask.push_back(odec_mask);
    end
  end

  function automatic logic [13:0] ref_hash(input logic [47:0] m);
    logic [55:0] x;
    logic [13:0] h;
    x = {8'h00, m};
    h = '0;
    for (int s = 0; s < 4; s++) h = h ^ 14'((x >> (14 * s)) & 56'h3FFF);
    return h;
  endfunction

  function automatic logic [3:0] ref_mask(input logic [1:0] port, input logic [47:0] da,
                                          input logic [1:0] pnum);
    logic [3:0] all_ports;
    all_ports = 4'hF;
    if (da == 48'hFFFF_FFFF_FFFF || da[40]) return all_ports & ~(4'b0001 << port);
    if (pnum == port) return 4'b0000;
    return 4'b0001 << pnum;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge iclk);
    #1;
  endtask

  task automatic clear_mon();
    wr_cyc.delete(); wr_sa.delete(); wr_da.delete(); wr_pn.delete();
    dec_cyc.delete(); dec_mask.delete();
  endtask

  task automatic send_bytes(input logic [1:0] port, input logic [47:0] da,
                            input logic [47:0] sa, input int nbytes, input int eof_idx);
    for (int i = 0; i < nbytes; i++) begin
      ivalid = 1'b1;
      isof   = (i == 0);
      ieof   = (i == eof_idx);
      iport  = (i == 0) ? port : 2'($urandom);
      if (i < 6)       idata = da[47-8*i -: 8];
      else if (i < 12) idata = sa[47-8*(i-6) -: 8];
      else             idata = 8'($urandom);
      tick();
    end
    ivalid = 1'b0; isof = 1'b0; ieof = 1'b0;
  endtask

  task automatic wait_dec(input int budget);
    for (int c = 0; c < budget && dec_cyc.size() == 0; c++) tick();
    repeat (6) tick();
  endtask

  task automatic check_txn(input string tag, input logic [1:0] port, input logic [47:0] da,
                           input logic [47:0] sa, input logic [3:0] mask, input int nwr);
    chk({tag, "_wr_count"}, wr_cyc.size(), nwr);
    chk({tag, "_dec_count"}, dec_cyc.size(), 1);
    if (wr_cyc.size() > 0) begin
      chk({tag, "_opnum"}, wr_pn[$], port);
      chk({tag, "_oda"}, wr_da[$], ref_hash(da));
      chk({tag, "_osa"}, wr_sa[$], ref_hash(sa));
    end
    if (dec_cyc.size() > 0) begin
      chk({tag, "_mask"}, dec_mask[0], mask);
      if (wr_cyc.size() > 0) chk({tag, "_latency"}, dec_cyc[0] - wr_cyc[$], 1 + LAT);
    end
    chk({tag, "_idle"}, obusy, 1'b0);
  endtask

  task automatic run_txn(input string tag, input logic [1:0] port, input logic [47:0] da,
                         input logic [47:0] sa, input logic [1:0] pnum, input logic [3:0] mask);
    clear_mon();
    itbl_ready = 1'b1;
    itbl_pnum  = pnum;
    send_bytes(port, da, sa, 14, 13);
    wait_dec(40);
    check_txn(tag, port, da, sa, mask, 1);
  endtask

  typedef struct {
    logic [1:0]  port;
    logic [47:0] da;
    logic [47:0] sa;
    logic [1:0]  pnum;
    logic [3:0]  mask;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  rp, rn;
    logic [47:0] rda, rsa;

    vecs[0] = '{port: 2'd2, da: 48'h0011_2233_4455, sa: 48'h6677_8899_AABB, pnum: 2'd1, mask: 4'b0010};
    vecs[1] = '{port: 2'd0, da: 48'hFFFF_FFFF_FFFF, sa: 48'h0200_0000_0001, pnum: 2'd2, mask: 4'b1110};
    vecs[2] = '{port: 2'd3, da: 48'h0200_0000_0001, sa: 48'h0200_0000_0002, pnum: 2'd3, mask: 4'b0000};
    vecs[3] = '{port: 2'd1, da: 48'h0100_5E00_0001, sa: 48'h0A0B_0C0D_0E0F, pnum: 2'd1, mask: 4'b1101};
    vecs[4] = '{port: 2'd0, da: 48'h00AA_BBCC_DDEE, sa: 48'h1234_5678_9ABC, pnum: 2'd3, mask: 4'b1000};

    irst_n = 1'b0; ivalid = 1'b0; isof = 1'b0; ieof = 1'b0; idata = '0;
    iport = '0; itbl_ready = 1'b0; itbl_pnum = '0;
    repeat (3) tick();
    chk("rst_busy", obusy, 1'b0);
    chk("rst_wr_en", owr_en, 1'b0);
    chk("rst_dec_valid", odec_valid, 1'b0);
    chk("rst_oda", oda, 14'd0);
    chk("rst_runt", ocnt_runt, 16'd0);
    chk("rst_ovr", ocnt_ovr, 16'd0);
    irst_n = 1'b1;
    tick();

    // Directed vector table
    for (int v = 0; v < 5; v++)
      run_txn($sformatf("vec%0d", v), vecs[v].port, vecs[v].da, vecs[v].sa, vecs[v].pnum, vecs[v].mask);

    // Runt: ieof on byte 7
    clear_mon();
    send_bytes(2'd1, 48'h0011_2233_4455, 48'h6677_8899_AABB, 8, 7);
    exp_runt++;
    repeat (10) tick();
    chk("runt_wr_count", wr_cyc.size(), 0);
    chk("runt_dec_count", dec_cyc.size(), 0);
    chk("runt_counter", ocnt_runt, 16'(exp_runt));
    chk("runt_idle", obusy, 1'b0);

    // isof mid-header restarts the header with the new port
    itbl_ready = 1'b1;
    send_bytes(2'd3, 48'hDEAD_BEEF_0000, 48'h0, 4, 99);
    run_txn("restart", 2'd1, 48'h0022_4466_88AA, 48'h1357_9BDF_0246, 2'd2, 4'b0100);
    chk("restart_runt", ocnt_runt, 16'(exp_runt));
    chk("restart_ovr", ocnt_ovr, 16'(exp_ovr));

    // Window closed for 10 cycles, then dropped during WAIT
    clear_mon();
    itbl_ready = 1'b0;
    itbl_pnum  = 2'd3;
    send_bytes(2'd1, 48'h0A1B_2C3D_4E5F, 48'h0055_AA55_AA55, 12, 99);
    repeat (10) tick();
    chk("stall_no_wr", wr_cyc.size(), 0);
    chk("stall_busy", obusy, 1'b1);
    itbl_ready = 1'b1; tick();
    itbl_ready = 1'b0; tick();
    itbl_ready = 1'b1;
    wait_dec(40);
    check_txn("stall", 2'd1, 48'h0A1B_2C3D_4E5F, 48'h0055_AA55_AA55, 4'b1000, 2);

    // Second isof during WAIT is dropped and counted
    clear_mon();
    itbl_ready = 1'b1;
    itbl_pnum  = 2'd0;
    send_bytes(2'd2, 48'h0033_0033_0033, 48'h0044_0044_0044, 12, 99);
    tick();
    send_bytes(2'd3, 48'hFFFF_FFFF_FFFF, 48'h0, 4, 99);
    exp_ovr++;
    wait_dec(40);
    check_txn("ovr", 2'd2, 48'h0033_0033_0033, 48'h0044_0044_0044, 4'b0001, 1);
    chk("ovr_counter", ocnt_ovr, 16'(exp_ovr));

    // Randomized frames against the model
    for (int r = 0; r < 24; r++) begin
      rp  = 2'($urandom);
      rsa = {16'($urandom), 32'($urandom)};
      rda = {16'($urandom), 32'($urandom)};
      case ($urandom_range(0, 3))
        0:       rda = 48'hFFFF_FFFF_FFFF;
        1:       rda[40] = 1'b1;
        default: rda[40] = 1'b0;
      endcase
      rn = ($urandom_range(0, 3) == 0) ? rp : 2'($urandom);
      run_txn($sformatf("rnd%0d", r), rp, rda, rsa, rn, ref_mask(rp, rda, rn));
    end
    chk("rnd_runt", ocnt_runt, 16'(exp_runt));
    chk("rnd_ovr", ocnt_ovr, 16'(exp_ovr));

    // Reset pulse during WAIT
    clear_mon();
    itbl_ready = 1'b1;
    itbl_pnum  = 2'd1;
    send_bytes(2'd0, 48'h0011_2233_4455, 48'h6677_8899_AABB, 12, 99);
    tick();
    chk("prerst_wr_count", wr_cyc.size(), 1);
    chk("prerst_busy", obusy, 1'b1);
    irst_n = 1'b0;
    #1;
    chk("midrst_oda", oda, 14'd0);
    chk("midrst_osa", osa, 14'd0);
    chk("midrst_opnum", opnum, 2'd0);
    chk("midrst_wr_en", owr_en, 1'b0);
    chk("midrst_dec_valid", odec_valid, 1'b0);
    chk("midrst_mask", odec_mask, 4'd0);
    chk("midrst_busy", obusy, 1'b0);
    chk("midrst_runt", ocnt_runt, 16'd0);
    chk("midrst_ovr", ocnt_ovr, 16'd0);
    clear_mon();
    tick();
    irst_n = 1'b1;
    repeat (20) tick();
    chk("postrst_wr_count", wr_cyc.size(), 0);
    chk("postrst_dec_count", dec_cyc.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
